mvu_agu_nloop: RTL
==================

Name: mvu_agu_nloop

Overview:
- Parametrised nested-loop address generator for MVU memory ports (weight, input, scaler, bias, output, high-precision).
- Generalises the fixed 5-loop jump/length scheme to NLOOPS loops with configurable address and count widths.
- Adds a valid/ready output handshake so downstream stalls freeze the address stream.
- Emits per-address loop-wrap flags that drive the shift-accumulator load and the pool/activation clear.
- One instance per address stream, inside each MVU, fed from CSR-captured configuration.

Parameters:
- NLOOPS, 5, number of loops; jump_0..jump_{NLOOPS-1}, length_1..length_{NLOOPS-1}
- BADDR, 15, address width; arithmetic is modulo 2^BADDR
- BJUMP, 15, jump width, two's complement signed
- BLENGTH, 15, loop length width
- BCNTDWN, 29, total address count width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  pulse; captures the configuration and begins a run when idle
- base_addr  in  BADDR  first address
- jump  in  NLOOPS*BJUMP  packed signed jumps; jump_0 in LSBs
- length  in  (NLOOPS-1)*BLENGTH  packed lengths; length_1 in LSBs; value = iterations-1
- countdown  in  BCNTDWN  number of addresses to emit
- addr_limit  in  BADDR  exclusive upper bound (optional-feature input)
- out_valid  out  1  addr/wrap valid
- out_ready  in  1  consumer accepts
- addr  out  BADDR  current address
- wrap  out  NLOOPS-1  wrap[j-1]=1: counter j wrapped to produce this address
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- oob_err  out  1  sticky out-of-bounds flag

Behaviour:
- Reset values: out_valid=0, addr=0, wrap=0, busy=0, done=0, oob_err=0; all counters 0.
- FSM states:
  - IDLE: start with countdown=0 -> done=1 for the next cycle, stay IDLE. start with countdown>0 -> RUN.
  - RUN: out_valid=1.
  - DONE: done=1 for one cycle, then IDLE.
- Entering RUN: the cycle after start, addr=base_addr, wrap=0, busy=1, remaining=countdown, counter c_j=length_j.
- Inputs are sampled only at start. Changes while busy are ignored.
- start while busy is ignored.
- A transfer occurs when out_valid & out_ready. With out_ready=0, addr/wrap/counters hold.
- On a transfer with remaining=1: go to DONE. out_valid=0 and busy=0 in the DONE cycle.
- On any other transfer, compute the next address:
  - k = count of consecutive counters from c_1 upward that equal 0; k is in 0..NLOOPS-1.
  - next addr = addr + sign_extend(jump_k), truncated to BADDR; wraps silently.
  - c_1..c_k reload to length.
  - If k<NLOOPS-1, c_{k+1} decrements.
  - If k=NLOOPS-1, all counters reload and the pattern repeats.
  - next wrap[j-1] = (j<=k).
  - remaining decrements.
- Throughput: one address per cycle with out_ready held high. Start-to-first-valid latency is 1 cycle.
- Reset asserted mid-run returns to IDLE with reset values immediately (asynchronous). No done pulse.
- length_j=0: loop j wraps on every step it is examined.

Optional Feature:
- Macro: MVU_AGU_BOUNDS_CHK_EN.
- Defined:
  - Any emitted address (out_valid=1) with addr>=addr_limit sets oob_err.
  - oob_err stays set until rst or the next accepted start.
  - The stream continues unchanged.
- Undefined: oob_err is tied 0, addr_limit is unused, and no comparator is built.

Decomposition:
- mvu_pkg additions:
  - AGU_NLOOPS default (=NJUMPS).
  - typedef agu_cfg_t: packed struct of base, jumps, lengths, countdown.
  - typedef agu_state_e {IDLE, RUN, DONE}.
- Sub-module mvu_agu_loopcnt: one reloadable down-counter.
  - Inputs: load, dec, length.
  - Outputs: zero flag.
  - Instantiated NLOOPS-1 times via generate.
- Top level holds the FSM, the k priority encoder, the adder and the handshake.

Test Plan:
- NLOOPS=2, base=100, jump0=1, jump1=10, length1=2, countdown=6, out_ready=1.
  - Addrs 100,101,102,112,113,114 on consecutive cycles; wrap=1 only on 112.
  - done pulses the cycle after 114.
- NLOOPS=3, base=0, jump0=1, jump1=8, jump2=-20, length1=1, length2=1, countdown=6.
  - Addrs 0,1,9,10,32758,32759.
  - wrap=01 on 9, 11 on 32758, 00 elsewhere.
- Repeat test 1 with out_ready low for 3 cycles while addr=101.
  - addr holds at 101 with out_valid=1; resumes with 102; done 3 cycles later than test 1.
- start with countdown=0 -> done one cycle later, out_valid never 1, busy stays 0.
- Mid-run checks:
  - Assert rst after 2 transfers -> all outputs return to 0 asynchronously, no done pulse.
  - After reset, a new start works normally.
  - A second start while busy does not restart the sequence.
- MVU_AGU_BOUNDS_CHK_EN with addr_limit=113 on test 1 -> oob_err rises with addr=113, stays 1 through done.
  - Without the macro, oob_err stays 0.

Source files
------------

// File: rtl/mvu_agu_nloop_pkg.sv
// Shared sizes and types for the MVU nested-loop address generator.
// Optional bounds checking in the top is enabled with MVU_AGU_BOUNDS_CHK_EN.
package mvu_agu_nloop_pkg;

  localparam int unsigned NJUMPS      = 5;
  localparam int unsigned AGU_NLOOPS  = NJUMPS;
  localparam int unsigned AGU_BADDR   = 15;
  localparam int unsigned AGU_BJUMP   = 15;
  localparam int unsigned AGU_BLENGTH = 15;
  localparam int unsigned AGU_BCNTDWN = 29;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } agu_state_e;

  // Configuration captured from CSRs at start (default sizes).
  typedef struct packed {
    logic [AGU_BCNTDWN-1:0]                 countdown;
    logic [(AGU_NLOOPS-1)*AGU_BLENGTH-1:0]  lengths;
    logic [AGU_NLOOPS*AGU_BJUMP-1:0]        jumps;
    logic [AGU_BADDR-1:0]                   base;
  } agu_cfg_t;

endpackage

// File: rtl/mvu_agu_nloop_loopcnt.sv
// One reloadable loop down-counter; reports when it has reached zero.
module mvu_agu_loopcnt
  import mvu_agu_nloop_pkg::*;
#(
  parameter int unsigned BLENGTH = AGU_BLENGTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [BLENGTH-1:0] length,
  output logic               zero_c
);

  logic [BLENGTH-1:0] cnt_q, cnt_d;

  // Reload has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = length;
    end else if (dec) begin
      cnt_d = cnt_q - BLENGTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mvu_agu_nloop.sv
// Nested-loop address generator with valid/ready output and per-address wrap flags.
// Define MVU_AGU_BOUNDS_CHK_EN to build the sticky out-of-bounds detector.
module mvu_agu_nloop
  import mvu_agu_nloop_pkg::*;
#(
  parameter int unsigned NLOOPS  = AGU_NLOOPS,
  parameter int unsigned BADDR   = AGU_BADDR,
  parameter int unsigned BJUMP   = AGU_BJUMP,
  parameter int unsigned BLENGTH = AGU_BLENGTH,
  parameter int unsigned BCNTDWN = AGU_BCNTDWN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BADDR-1:0]              base_addr,
  input  logic [NLOOPS*BJUMP-1:0]       jump,
  input  logic [(NLOOPS-1)*BLENGTH-1:0] length,
  input  logic [BCNTDWN-1:0]            countdown,
  input  logic [BADDR-1:0]              addr_limit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BADDR-1:0]              addr,
  output logic [NLOOPS-2:0]             wrap,
  output logic                          busy,
  output logic                          done,
  output logic                          oob_err
);

  localparam int unsigned NCNT = NLOOPS - 1;
  localparam int unsigned KW   = $clog2(NLOOPS);

  agu_state_e                state_q, state_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [BADDR-1:0]          addr_q, addr_d;
  logic [NCNT-1:0]           wrap_q, wrap_d;
  logic [BCNTDWN-1:0]        remaining_q, remaining_d;
  logic [NLOOPS*BJUMP-1:0]   jump_q, jump_d;
  logic [NCNT*BLENGTH-1:0]   len_q, len_d;

  logic                      accept_c, xfer_c, last_c, adv_c;
  logic [NCNT-1:0]           cnt_zero_c, cnt_load_c, cnt_dec_c;
  logic [NCNT*BLENGTH-1:0]   cnt_len_c;
  logic [KW-1:0]             k_c;
  logic                      k_stop_c;
  logic [BJUMP-1:0]          jump_k_c;
  logic [BADDR-1:0]          addr_next_c;

  assign accept_c = (state_q == IDLE) && start;
  assign xfer_c   = out_valid_q && out_ready;
  assign last_c   = (remaining_q == BCNTDWN'(1));
  assign adv_c    = xfer_c && !last_c;

  // k = number of consecutive exhausted counters starting at c_1.
  always_comb begin
    k_c      = '0;
    k_stop_c = 1'b0;
    for (int j = 0; j < int'(NCNT); j++) begin
      if (!k_stop_c) begin
        if (cnt_zero_c[j]) begin
          k_c = KW'(j + 1);
        end else begin
          k_stop_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    jump_k_c = jump_q[BJUMP-1:0];
    for (int j = 1; j < int'(NLOOPS); j++) begin
      if (k_c == KW'(j)) begin
        jump_k_c = jump_q[j*BJUMP +: BJUMP];
      end
    end
  end

  // Signed jump, modulo 2^BADDR.
  assign addr_next_c = addr_q + BADDR'($signed(jump_k_c));

  // Counters below k reload; counter k+1 (if any) steps down.
  assign cnt_len_c = accept_c ? length : len_q;

  always_comb begin
    cnt_load_c = '0;
    cnt_dec_c  = '0;
    for (int j = 0; j < int'(NCNT); j++) begin
      cnt_load_c[j] = accept_c || (adv_c && (KW'(j) < k_c));
      cnt_dec_c[j]  = adv_c && (k_c == KW'(j));
    end
  end

  for (genvar g = 0; g < int'(NCNT); g++) begin : g_cnt
    mvu_agu_loopcnt #(
      .BLENGTH (BLENGTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (cnt_load_c[g]),
      .dec    (cnt_dec_c[g]),
      .length (cnt_len_c[g*BLENGTH +: BLENGTH]),
      .zero_c (cnt_zero_c[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    addr_d      = addr_q;
    wrap_d      = wrap_q;
    remaining_d = remaining_q;
    jump_d      = jump_q;
    len_d       = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          jump_d = jump;
          len_d  = length;
          if (countdown == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            addr_d      = base_addr;
            wrap_d      = '0;
            remaining_d = countdown;
          end
        end
      end
      RUN: begin
        if (xfer_c) begin
          if (last_c) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            addr_d      = addr_next_c;
            remaining_d = remaining_q - BCNTDWN'(1);
            for (int j = 0; j < int'(NCNT); j++) begin
              wrap_d[j] = (KW'(j) < k_c);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      wrap_q      <= '0;
      remaining_q <= '0;
      jump_q      <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      wrap_q      <= wrap_d;
      remaining_q <= remaining_d;
      jump_q      <= jump_d;
      len_q       <= len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign addr      = addr_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MVU_AGU_BOUNDS_CHK_EN
  logic [BADDR-1:0] limit_q, limit_d;
  logic             oob_q, oob_d;

  // Flag is evaluated on the address about to be presented, so it rises with it.
  always_comb begin
    limit_d = limit_q;
    oob_d   = oob_q;
    if (accept_c) begin
      limit_d = addr_limit;
      oob_d   = (countdown != '0) && (base_addr >= addr_limit);
    end else if (adv_c) begin
      oob_d = oob_q || (addr_next_c >= limit_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_q <= '0;
      oob_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      oob_q   <= oob_d;
    end
  end

  assign oob_err = oob_q;
`else
  logic unused_addr_limit;
  assign unused_addr_limit = ^addr_limit;
  assign oob_err           = 1'b0;
`endif

endmodule
